// File: rtl/npc_mem_responder.sv
// npc_mem_responder: word-organised SRAM model answering the core's ifu and
// lsu request ports. One access in flight at a time, round-robin arbitration.
// Optional feature macro: MEM_RAND_DELAY_EN. When it is defined, each access
// gets a pseudo-random latency from an LFSR instead of the fixed LATENCY.
//
// Handshake: an initiator raises reqValid with its address and data and holds
// them stable until its respValid pulses for one cycle. The request is sampled
// only at the grant edge. If reqValid is still high in the cycle after
// respValid, that is treated as a new request.
module npc_mem_responder #(
  parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
  parameter int          DEPTH     = 4096,
  parameter int          LATENCY   = 2,
  parameter int          LFSR_W    = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ifu_reqValid,
  input  logic [31:0] ifu_addr,
  output logic        ifu_respValid,
  output logic [31:0] ifu_rdata,
  input  logic        lsu_reqValid,
  input  logic [31:0] lsu_addr,
  input  logic [1:0]  lsu_size,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_respValid,
  output logic [31:0] lsu_rdata,
  output logic [1:0]  dbg_state,
  output logic [1:0]  dbg_size
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = (LFSR_W > $clog2(LATENCY + 1)) ? LFSR_W : $clog2(LATENCY + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic PORT_IFU = 1'b0;
  localparam logic PORT_LSU = 1'b1;

  // First byte address past the array, kept 33 bits wide so it cannot wrap.
  localparam logic [32:0] ADDR_END = {1'b0, ADDR_BASE} + 33'(4 * DEPTH);

  logic [31:0]      mem [DEPTH];
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_init;
  logic             rr_last;
  logic             sel_port;
  logic             sel_wen;
  logic [31:0]      sel_addr;
  logic [31:0]      sel_wdata;
  logic [3:0]       sel_wmask;
  logic [1:0]       sel_size;
  logic             grant_valid;
  logic             grant_port;
  logic [AW-1:0]    idx;
  logic             in_range;
  logic             do_access;

  assign dbg_state = state;
  assign dbg_size  = sel_size;

  // Round-robin pick: contested grants go to the port not served last.
  always_comb begin
    grant_valid = ifu_reqValid | lsu_reqValid;
    if (ifu_reqValid && lsu_reqValid) grant_port = ~rr_last;
    else                              grant_port = lsu_reqValid ? PORT_LSU : PORT_IFU;
  end

`ifdef MEM_RAND_DELAY_EN
  localparam logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(4'b1100);
  localparam logic [LFSR_W-1:0] LFSR_SEED = LFSR_W'(4'b1001);
  logic [LFSR_W-1:0] lfsr;

  // Galois LFSR (x^4+x^3+1), free-running every cycle; never reaches zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) lfsr <= LFSR_SEED;
    else        lfsr <= {1'b0, lfsr[LFSR_W-1:1]} ^ (lfsr[0] ? LFSR_TAPS : '0);
  end

  assign cnt_init = CNT_W'(lfsr);
`else
  assign cnt_init = CNT_W'(LATENCY - 1);
`endif

  // Address decode of the latched request; low two bits do not affect the index.
  assign idx       = AW'((sel_addr - ADDR_BASE) >> 2);
  assign in_range  = ({1'b0, sel_addr} >= {1'b0, ADDR_BASE}) && ({1'b0, sel_addr} < ADDR_END);
  assign do_access = (state == S_WAIT) && (cnt == '0);

  // Control FSM: grant in IDLE, count down in WAIT, pulse the response in RESP.
  // Every grant passes through WAIT, so the latency is cnt_init+1 cycles.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      cnt           <= '0;
      rr_last       <= PORT_LSU;
      sel_port      <= PORT_IFU;
      sel_wen       <= 1'b0;
      sel_addr      <= '0;
      sel_wdata     <= '0;
      sel_wmask     <= '0;
      sel_size      <= '0;
      ifu_respValid <= 1'b0;
      lsu_respValid <= 1'b0;
      ifu_rdata     <= '0;
      lsu_rdata     <= '0;
    end else begin
      ifu_respValid <= 1'b0;
      lsu_respValid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_valid) begin
            state     <= S_WAIT;
            cnt       <= cnt_init;
            rr_last   <= grant_port;
            sel_port  <= grant_port;
            sel_addr  <= (grant_port == PORT_LSU) ? lsu_addr : ifu_addr;
            sel_wen   <= (grant_port == PORT_LSU) & lsu_wen;
            sel_wdata <= lsu_wdata;
            sel_wmask <= lsu_wmask;
            sel_size  <= (grant_port == PORT_LSU) ? lsu_size : 2'd2;
          end
        end
        S_WAIT: begin
          if (cnt == '0) begin
            state <= S_RESP;
            if (sel_port == PORT_LSU) begin
              lsu_respValid <= 1'b1;
              lsu_rdata     <= (sel_wen || !in_range) ? 32'h0 : mem[idx];
            end else begin
              ifu_respValid <= 1'b1;
              ifu_rdata     <= in_range ? mem[idx] : 32'h0;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Byte-masked array write. It happens only on the access edge, so a reset
  // that arrives earlier leaves the array untouched.
  always_ff @(posedge clock) begin
    if (do_access && sel_wen && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (sel_wmask[b]) mem[idx][8*b +: 8] <= sel_wdata[8*b +: 8];
      end
    end
  end

endmodule
